// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and constants for the unified memory arbiter.
package mem_arb_pkg;
  typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IRESP, DRESP} arb_state_t;
  localparam int ARB_ERR_RDATA = 0;
endpackage

// File: rtl/arb_wait_timer.sv
// arb_wait_timer: counts stalled busy cycles and flags when the TIMEOUT bound is reached.
module arb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;
  assign o_expired = r_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en && !o_expired) r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between fetch and data ports,
// with a bounded wait per transaction and a cap on consecutive data grants.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int TIMEOUT      = 16,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          istall,
  input  logic          dreq,
  input  logic          dwe,
  input  logic          dbyte,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dstall,
  output logic          mem_req,
  output logic          mem_we,
  output logic          mem_byte,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          bus_err
);
  localparam int RW = $clog2(MAX_DATA_RUN + 1);
  arb_state_t    r_state;
  logic [RW-1:0] r_run;
  logic          w_busy, w_expired, w_run_full, w_dgrant;
  logic [DW-1:0] w_rdata;
  assign w_busy     = r_state == IBUSY || r_state == DBUSY;
  assign w_run_full = r_run >= RW'(MAX_DATA_RUN);
  assign w_dgrant   = dreq && !(ireq && w_run_full);
  assign w_rdata    = mem_ready ? mem_rdata : DW'(ARB_ERR_RDATA);
  assign istall     = ireq && r_state != IRESP;
  assign dstall     = dreq && r_state != DRESP;
  arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (!w_busy || mem_ready),
    .i_en     (w_busy && !mem_ready),
    .o_expired(w_expired)
  );
  // A ready in the expiry cycle still wins over the abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_run     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_byte  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      irdata    <= '0;
      drdata    <= '0;
      bus_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!ireq) r_run <= '0;
          if (w_dgrant) begin
            r_state   <= DBUSY;
            mem_req   <= 1'b1;
            mem_we    <= dwe;
            mem_byte  <= dbyte;
            mem_addr  <= daddr;
            mem_wdata <= dwdata;
            if (ireq) r_run <= r_run + RW'(1);
          end else if (ireq) begin
            r_state   <= IBUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_byte  <= 1'b0;
            mem_addr  <= iaddr;
            mem_wdata <= '0;
            r_run     <= '0;
          end
        end
        IBUSY, DBUSY: begin
          if (mem_ready || w_expired) begin
            r_state <= r_state == IBUSY ? IRESP : DRESP;
            mem_req <= 1'b0;
            if (r_state == IBUSY) irdata <= w_rdata;
            else drdata <= w_rdata;
            if (!mem_ready) bus_err <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
